// File: rtl/mux_arb_if.sv
// Bus between the round-robin arbiter and its requesters / mux consumer.
// The lock signal exists only when MUX_ARB_LOCK_EN is defined.
interface mux_arb_if;
  logic [3:0] req;
  logic [3:0] in;
`ifdef MUX_ARB_LOCK_EN
  logic       lock;
`endif
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       out;
  logic       out_valid;
  logic       busy;

  // Requester side: drives requests/data, observes grant and muxed bit.
  modport master (
    output req, in,
`ifdef MUX_ARB_LOCK_EN
    output lock,
`endif
    input  gnt, sel, out, out_valid, busy
  );

  // Arbiter side.
  modport slave (
    input  req, in,
`ifdef MUX_ARB_LOCK_EN
    input  lock,
`endif
    output gnt, sel, out, out_valid, busy
  );
endinterface

// File: rtl/mux_4to1_rr_arbiter.sv
// Round-robin arbiter owning the select of a 4:1 single-bit mux.
// A hold counter forces rotation after MAX_HOLD cycles when another source
// waits. Optional feature macro: MUX_ARB_LOCK_EN adds a lock input that
// extends the current grant past the hold limit.
module mux_4to1_rr_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input logic      clk,
  input logic      rst,
  mux_arb_if.slave bus
);

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state, state_n;
  logic [1:0] last, last_n;
  logic [3:0] hcnt, hcnt_n;
  logic [1:0] sel_q, sel_n;
  logic [3:0] gnt_q;
  logic       out_q, ov_q;

  logic [3:0] others;
  logic       any_found, oth_found, grant_new, hold_ext;
  logic [1:0] any_idx, oth_idx, new_idx;

  // First set bit searching last+1, last+2, last+3, last (mod 4).
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
    logic [1:0] idx;
    logic       found;
    logic [2:0] res;
    found = 1'b0;
    res   = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && r[idx]) begin
        found = 1'b1;
        res   = {1'b1, idx};
      end
    end
    return res;
  endfunction

  // Next-state: grant selection, hold counting and rotation.
  always_comb begin
    state_n   = state;
    last_n    = last;
    hcnt_n    = hcnt;
    sel_n     = sel_q;
    grant_new = 1'b0;
    new_idx   = '0;
    hold_ext  = 1'b0;
`ifdef MUX_ARB_LOCK_EN
    hold_ext  = bus.lock;
`endif
    // While granted, sel_q is the current owner.
    others                 = bus.req & ~(4'b0001 << sel_q);
    {any_found, any_idx}   = rr_pick(bus.req, last);
    {oth_found, oth_idx}   = rr_pick(others, last);

    case (state)
      IDLE: begin
        if (any_found) begin
          grant_new = 1'b1;
          new_idx   = any_idx;
        end
      end
      GRANT: begin
        if (!bus.req[sel_q]) begin
          // Release; hand over on the same edge if anyone else waits.
          if (any_found) begin
            grant_new = 1'b1;
            new_idx   = any_idx;
          end else begin
            state_n = IDLE;
            hcnt_n  = '0;
          end
        end else if (hcnt < HOLD_MAX) begin
          hcnt_n = hcnt + 4'd1;
        end else if (!hold_ext && oth_found) begin
          grant_new = 1'b1;
          new_idx   = oth_idx;
        end
        // Otherwise keep the grant with hcnt saturated.
      end
      default: state_n = IDLE;
    endcase

    if (grant_new) begin
      state_n = GRANT;
      last_n  = new_idx;
      sel_n   = new_idx;
      hcnt_n  = 4'd1;
    end
  end

  // State and registered outputs; out tracks in[next sel] every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last  <= 2'd3;
      hcnt  <= '0;
      sel_q <= '0;
      gnt_q <= '0;
      out_q <= 1'b0;
      ov_q  <= 1'b0;
    end else begin
      state <= state_n;
      last  <= last_n;
      hcnt  <= hcnt_n;
      sel_q <= sel_n;
      gnt_q <= (state_n == GRANT) ? (4'b0001 << sel_n) : 4'b0000;
      out_q <= bus.in[sel_n];
      ov_q  <= (state_n == GRANT);
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.out       = out_q;
  assign bus.out_valid = ov_q;
  assign bus.busy      = (state == GRANT);

endmodule

// File: tb/tb_mux_4to1_rr_arbiter.sv
// Bench for mux_4to1_rr_arbiter: vector table, corner sequences, and a
// randomized run checked against an ownership-based reference model.
module tb_mux_4to1_rr_arbiter;

  localparam int MAX_HOLD = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_arb_if bus ();

  mux_4to1_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       out;
    logic       ov;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: who owns the path, for how long, pointer.
  int   m_owner;
  int   m_held;
  int   m_ptr;
  int   m_sel;
  logic m_out;

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] g, input logic [1:0] s,
                           input logic o, input logic v);
    check({tag, ".gnt"},  bus.gnt, g);
    check({tag, ".sel"},  {2'b00, bus.sel}, {2'b00, s});
    check({tag, ".out"},  {3'b000, bus.out}, {3'b000, o});
    check({tag, ".ov"},   {3'b000, bus.out_valid}, {3'b000, v});
    check({tag, ".busy"}, {3'b000, bus.busy}, {3'b000, (g != 4'b0000)});
  endtask

  task automatic cyc(input logic r, input logic [3:0] rq, input logic [3:0] d, input logic lk);
    rst     = r;
    bus.req = rq;
    bus.in  = d;
`ifdef MUX_ARB_LOCK_EN
    bus.lock = lk;
`endif
    @(posedge clk);
    #1;
  endtask

  // First requester scanning ptr+1 .. ptr+4 (mod 4); -1 if none.
  function automatic int first_from(input logic [3:0] r, input int ptr);
    for (int k = 1; k <= 4; k++)
      if (r[(ptr + k) % 4]) return (ptr + k) % 4;
    return -1;
  endfunction

  task automatic model_step(input logic r, input logic [3:0] rq, input logic [3:0] d, input logic lk);
    int w;
    if (r) begin
      m_owner = -1; m_held = 0; m_ptr = 3; m_sel = 0; m_out = 1'b0;
      return;
    end
    if (m_owner < 0 || !rq[m_owner]) begin
      w = first_from(rq, m_ptr);
      if (w >= 0) begin m_owner = w; m_held = 1; m_ptr = w; m_sel = w; end
      else begin m_owner = -1; m_held = 0; end
    end else if (m_held < MAX_HOLD) begin
      m_held++;
    end else if (!lk) begin
      w = first_from(rq & ~(4'b0001 << m_owner), m_ptr);
      if (w >= 0) begin m_owner = w; m_held = 1; m_ptr = w; m_sel = w; end
    end
    m_out = d[m_sel];
  endtask

  initial begin
    logic [3:0] g;
    logic       r, lk;
    logic [3:0] rq, d;
    int         src;

    rst = 1'b1; bus.req = '0; bus.in = '0;
`ifdef MUX_ARB_LOCK_EN
    bus.lock = 1'b0;
`endif

    // ---- vector table ----
    // Reset with all requesting.
    vecs.push_back('{1'b1, 4'b1111, 4'b1010, 4'b0000, 2'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'b1111, 4'b1010, 4'b0000, 2'd0, 1'b0, 1'b0});
    // Full rotation: 0,1,2,3 four cycles each, then back to 0.
    for (int i = 0; i < 17; i++) begin
      src = (i / MAX_HOLD) % 4;
      g   = 4'b0001 << src;
      vecs.push_back('{1'b0, 4'b1111, 4'b1010, g, 2'(src), src[0], 1'b1});
    end
    // Early release of source 2 hands straight to source 0, then idle.
    vecs.push_back('{1'b1, 4'b0000, 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 4'b0001, 4'b0100, 4'b0001, 2'd0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 4'b0000, 4'b0101, 4'b0000, 2'd0, 1'b1, 1'b0});

    @(posedge clk); #1;
    foreach (vecs[i]) begin
      cyc(vecs[i].rst, vecs[i].req, vecs[i].din, 1'b0);
      check_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].sel, vecs[i].out, vecs[i].ov);
    end

    // ---- sole requester holds indefinitely ----
    cyc(1'b1, 4'b0000, 4'b0000, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 4'b1000, 4'b1000, 1'b0);
      check_all($sformatf("sole%0d", i), 4'b1000, 2'd3, 1'b1, 1'b1);
    end

    // ---- reset mid-grant, pointer back to 3 ----
    cyc(1'b1, 4'b0000, 4'b0000, 1'b0);
    cyc(1'b0, 4'b0010, 4'b0010, 1'b0);
    cyc(1'b0, 4'b0010, 4'b0010, 1'b0);
    check_all("midgnt.pre", 4'b0010, 2'd1, 1'b1, 1'b1);
    cyc(1'b1, 4'b0010, 4'b0010, 1'b0);
    check_all("midrst", 4'b0000, 2'd0, 1'b0, 1'b0);
    cyc(1'b0, 4'b0110, 4'b0010, 1'b0);
    check_all("midrst.post", 4'b0010, 2'd1, 1'b1, 1'b1);

`ifdef MUX_ARB_LOCK_EN
    // ---- lock extends source 0 past the hold limit ----
    cyc(1'b1, 4'b0000, 4'b0000, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 4'b0011, 4'b0001, 1'b1);
      check_all($sformatf("lock%0d", i), 4'b0001, 2'd0, 1'b1, 1'b1);
    end
    cyc(1'b0, 4'b0011, 4'b0001, 1'b0);
    check_all("unlock", 4'b0010, 2'd1, 1'b0, 1'b1);
`endif

    // ---- randomized run against the model ----
    cyc(1'b1, 4'b0000, 4'b0000, 1'b0);
    model_step(1'b1, 4'b0000, 4'b0000, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 99) == 0);
      rq = ($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
      if ($urandom_range(0, 9) == 0) rq = 4'b0000;
      d  = 4'($urandom);
      lk = 1'b0;
`ifdef MUX_ARB_LOCK_EN
      lk = ($urandom_range(0, 3) == 0);
`endif
      cyc(r, rq, d, lk);
      model_step(r, rq, d, lk);
      check_all($sformatf("rnd%0d", i),
                (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000,
                2'(m_sel), m_out, (m_owner >= 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
